seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational 16-op ALU; same 4-bit op encoding, generic WIDTH.
- Add, sub, logic, shift, rotate and compare complete in one cycle. Multiply and divide are iterative, one bit per cycle, with no array multiplier or divider.
- Rotates take a variable amount (not fixed 1). Divide-by-zero has defined behaviour.
- Sits between the execute-stage decoder and the writeback register, with valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH), shift/rotate amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_sel  input  4  operation select (encoding below)
- out_valid  output  1  result valid; held until taken
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- neg  output  1  bit WIDTH-1 of (A-B) for captured operands

Behaviour:
- Ops (alu_sel):
  - 0 add; 1 sub; 2 mul (low WIDTH bits of product, unsigned); 3 div (unsigned quotient).
  - 4 shl by b; 5 shr logical by b. If b >= WIDTH, result = 0.
  - 6 rotl by b[SHW-1:0]; 7 rotr by b[SHW-1:0].
  - 8 and; 9 or; 10 xor; 11 nor; 12 nand; 13 xnor.
  - 14 result = 1 if A>B unsigned, else 0; 15 result = 1 if A==B, else 0.
- Arithmetic wraps modulo 2^WIDTH; no carry or overflow output.
- Divide by zero: result = all ones, same latency as a normal divide.
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; neg=0; iteration counter=0.
- Reset mid-operation abandons the operation in the same cycle. No result is produced.
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b, alu_sel; neg is computed from the latched operands.
    - Single-cycle op: result is written on the accept edge; go to DONE.
    - mul: clear accumulator and counter; go to MUL.
    - div: clear remainder and counter; go to DIV.
  - MUL: shift-add, one multiplier bit per edge, counter++. After the edge with counter==WIDTH-1, write result and go to DONE.
  - DIV: restoring division, one quotient bit per edge, counter++. After the edge with counter==WIDTH-1, write result and go to DONE.
  - DONE: out_valid=1; result, zero and neg are stable. On out_ready, go to IDLE.
- Latency (accept cycle = cycle 0):
  - Single-cycle ops: out_valid first high in cycle 1.
  - mul/div: out_valid first high in cycle WIDTH+1.
- Throughput: no overlap. After a result is taken, in_ready rises the next cycle, so the minimum spacing is 2 cycles per single-cycle op.
- out_valid is high only in DONE. in_valid and in_ready are ignored outside IDLE. Inputs a, b and alu_sel may change freely after accept.
- zero and neg are registered together with result and change only when result is written.
- A result held in DONE with out_ready low stays stable indefinitely (backpressure).

Test Plan:
- Reset check: assert rst for 2 cycles mid-MUL with a=7, b=9 -> next cycle out_valid=0, in_ready=1, result=0, zero=1; no result later appears.
- Single-cycle ops: add 0xFFFFFFFF+1 -> result=0, zero=1, out_valid in cycle 1. Then sub 3-5 -> result=0xFFFFFFFE, neg=1.
- Multiply: 0x0001_0001 * 0x0001_0001 -> result=0x0002_0001, out_valid first in cycle 33 (WIDTH=32). in_ready low for cycles 1..33.
- Divide: 100/7 -> result=14. Then 5/0 -> result=0xFFFFFFFF, same latency of 33 cycles.
- Shift/rotate: rotl a=0x8000_0001, b=4 -> 0x0000_0018. rotr b=36 -> same as b=4. shl b=32 -> result=0, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after an xor result 0xA5A5A5A5 -> result stable, in_ready=0. Drive in_valid with a new request during the stall -> not accepted; it is accepted in the cycle after out_ready.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle between the execute-stage decoder, the sequential ALU
// and the writeback register.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, result, zero, neg
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, result, zero, neg
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/shift/rotate/compare, plus
// bit-serial shift-add multiply and restoring divide (one bit per clock).
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             neg_reg, neg_next;
    logic             neg_pend_reg, neg_pend_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    // work: product accumulator (mul) or partial remainder (div)
    // opa:  shifting multiplicand (mul) or dividend/quotient (div)
    // opb:  shifting multiplier (mul) or divisor (div)
    logic [WIDTH-1:0] work_reg, work_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;

    // ---------------- single-cycle datapath on the live inputs ----------------
    logic [WIDTH-1:0]   and_v, or_v, xor_v;
    logic [WIDTH-1:0]   sub_in;
    logic [WIDTH-1:0]   single_res;
    logic [2*WIDTH-1:0] rotl_dbl, rotr_dbl;
    logic [SHW-1:0]     amt;
    logic               amt_big;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = bus.a[gi] & bus.b[gi];
            assign or_v[gi]  = bus.a[gi] | bus.b[gi];
            assign xor_v[gi] = bus.a[gi] ^ bus.b[gi];
        end
    endgenerate

    assign sub_in   = bus.a - bus.b;
    assign amt      = bus.b[SHW-1:0];
    // WIDTH is a power of two, so b >= WIDTH exactly when any bit above SHW is set
    assign amt_big  = |bus.b[WIDTH-1:SHW];
    assign rotl_dbl = {bus.a, bus.a} << amt;
    assign rotr_dbl = {bus.a, bus.a} >> amt;

    always_comb begin
        single_res = '0;
        case (bus.alu_sel)
            4'd0:    single_res = bus.a + bus.b;
            4'd1:    single_res = sub_in;
            4'd4:    single_res = amt_big ? '0 : (bus.a << amt);
            4'd5:    single_res = amt_big ? '0 : (bus.a >> amt);
            4'd6:    single_res = rotl_dbl[2*WIDTH-1:WIDTH];
            4'd7:    single_res = rotr_dbl[WIDTH-1:0];
            4'd8:    single_res = and_v;
            4'd9:    single_res = or_v;
            4'd10:   single_res = xor_v;
            4'd11:   single_res = ~or_v;
            4'd12:   single_res = ~and_v;
            4'd13:   single_res = ~xor_v;
            4'd14:   single_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            4'd15:   single_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            default: single_res = '0;
        endcase
    end

    // ---------------- iterative step logic ----------------
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             quo_bit;
    logic [WIDTH-1:0] quo_step;
    logic             last_iter;

    assign acc_sum   = work_reg + (opb_reg[0] ? opa_reg : '0);
    assign rem_shift = {work_reg, opa_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_reg};
    // A zero divisor always "fits", which yields the all-ones quotient for free
    assign quo_bit   = (rem_shift >= {1'b0, opb_reg});
    assign quo_step  = {opa_reg[WIDTH-2:0], quo_bit};
    assign last_iter = (cnt_reg == SHW'(WIDTH - 1));

    always_comb begin
        state_next    = state_reg;
        result_next   = result_reg;
        zero_next     = zero_reg;
        neg_next      = neg_reg;
        neg_pend_next = neg_pend_reg;
        cnt_next      = cnt_reg;
        work_next     = work_reg;
        opa_next      = opa_reg;
        opb_next      = opb_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    neg_pend_next = sub_in[WIDTH-1];
                    cnt_next      = '0;
                    work_next     = '0;
                    opa_next      = bus.a;
                    opb_next      = bus.b;
                    if (bus.alu_sel == OP_MUL) begin
                        state_next = ST_MUL;
                    end else if (bus.alu_sel == OP_DIV) begin
                        state_next = ST_DIV;
                    end else begin
                        result_next = single_res;
                        zero_next   = (single_res == '0);
                        neg_next    = sub_in[WIDTH-1];
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                work_next = acc_sum;
                opa_next  = opa_reg << 1;
                opb_next  = opb_reg >> 1;
                cnt_next  = cnt_reg + 1'b1;
                if (last_iter) begin
                    result_next = acc_sum;
                    zero_next   = (acc_sum == '0);
                    neg_next    = neg_pend_reg;
                    state_next  = ST_DONE;
                end
            end
            ST_DIV: begin
                work_next = quo_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                opa_next  = quo_step;
                cnt_next  = cnt_reg + 1'b1;
                if (last_iter) begin
                    result_next = quo_step;
                    zero_next   = (quo_step == '0);
                    neg_next    = neg_pend_reg;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            result_reg   <= '0;
            zero_reg     <= 1'b1;
            neg_reg      <= 1'b0;
            neg_pend_reg <= 1'b0;
            cnt_reg      <= '0;
            work_reg     <= '0;
            opa_reg      <= '0;
            opb_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            result_reg   <= result_next;
            zero_reg     <= zero_next;
            neg_reg      <= neg_next;
            neg_pend_reg <= neg_pend_next;
            cnt_reg      <= cnt_next;
            work_reg     <= work_next;
            opa_reg      <= opa_next;
            opb_reg      <= opb_next;
        end
    end

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.neg       = neg_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int n;
        n = int'(y % 32);
        case (op)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  begin p = 64'(x) * 64'(y); return p[31:0]; end
            4'd3:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd4:  return (y >= 32) ? 32'd0 : x << y;
            4'd5:  return (y >= 32) ? 32'd0 : x >> y;
            4'd6:  return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
            4'd7:  return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
            4'd8:  return x & y;
            4'd9:  return x | y;
            4'd10: return x ^ y;
            4'd11: return ~(x | y);
            4'd12: return ~(x & y);
            4'd13: return ~(x ^ y);
            4'd14: return (x > y) ? 32'd1 : 32'd0;
            default: return (x == y) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic model_neg(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x - y;
        return d[31];
    endfunction

    // Drives one request from a negedge, returns the observed response and the
    // cycle (relative to the accept cycle) in which out_valid first appeared.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic z, output logic n,
                          output int lat, output int rdy_leak);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1; bus.a = x; bus.b = y; bus.alu_sel = op; bus.out_ready = 1'b0;
        @(posedge clk);
        lat = -1; rdy_leak = 0; res = 'x; z = 1'bx; n = 1'bx;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.alu_sel = 4'($urandom);
            end
            if (bus.in_ready !== 1'b0) rdy_leak++;
            if (bus.out_valid === 1'b1) begin
                lat = c; res = bus.result; z = bus.zero; n = bus.neg;
                break;
            end
        end
        if (lat > 0) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.alu_sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0 ||
            bus.zero !== 1'b1 || bus.neg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h z=%b n=%b required 1 0 00000000 1 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.neg);
        end
        // abandon a multiply in flight
        bus.in_valid = 1'b1; bus.a = 32'd7; bus.b = 32'd9; bus.alu_sel = 4'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_mul: rdy=%b vld=%b res=%h z=%b required 1 0 00000000 1",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_result: out_valid appeared=%b required 0", seen);
        end
        $display("reset: checked idle state and abandoned multiply");
    endtask

    task automatic test_single_cycle();
        logic [3:0] ops[$];
        logic [31:0] xs[$], ys[$];
        logic [31:0] res, exp;
        logic z, n;
        int lat, leak;
        ops = {4'd0, 4'd1, 4'd14, 4'd14, 4'd15, 4'd15};
        xs  = {32'hFFFF_FFFF, 32'd3, 32'd5, 32'd5, 32'h1234, 32'h1234};
        ys  = {32'd1, 32'd5, 32'd4, 32'd5, 32'h1234, 32'h1235};
        for (int i = 0; i < 20; i++) begin
            ops.push_back(4'($urandom_range(0, 1)) | (($urandom_range(0, 1) != 0) ? 4'd8 : 4'd0));
            xs.push_back($urandom); ys.push_back($urandom);
        end
        foreach (ops[i]) begin
            run_op(ops[i], xs[i], ys[i], res, z, n, lat, leak);
            exp = model(ops[i], xs[i], ys[i]);
            n_vec++;
            if (res !== exp || z !== (exp == 0) || n !== model_neg(xs[i], ys[i]) || lat != 1 || leak != 0) begin
                n_err++;
                $display("FAIL single op=%0d a=%h b=%h: res=%h z=%b n=%b lat=%0d leak=%0d required %h %b %b 1 0",
                         ops[i], xs[i], ys[i], res, z, n, lat, leak, exp, exp == 0, model_neg(xs[i], ys[i]));
            end
            $display("single op=%0d a=%h b=%h -> %h lat=%0d", ops[i], xs[i], ys[i], res, lat);
        end
    endtask

    task automatic test_iterative();
        logic [3:0] ops[$];
        logic [31:0] xs[$], ys[$];
        logic [31:0] res, exp;
        logic z, n;
        int lat, leak;
        ops = {4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        xs  = {32'h0001_0001, 32'hFFFF_FFFF, 32'd100, 32'd5, 32'd3, 32'hFFFF_FFFF};
        ys  = {32'h0001_0001, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd9, 32'd1};
        for (int i = 0; i < 8; i++) begin
            ops.push_back((i % 2 == 0) ? 4'd2 : 4'd3);
            xs.push_back($urandom);
            ys.push_back((i % 4 == 1) ? 32'($urandom_range(0, 300)) : $urandom);
        end
        foreach (ops[i]) begin
            run_op(ops[i], xs[i], ys[i], res, z, n, lat, leak);
            exp = model(ops[i], xs[i], ys[i]);
            n_vec++;
            if (res !== exp || z !== (exp == 0) || n !== model_neg(xs[i], ys[i]) || lat != W + 1 || leak != 0) begin
                n_err++;
                $display("FAIL iterative op=%0d a=%h b=%h: res=%h z=%b n=%b lat=%0d leak=%0d required %h %b %b %0d 0",
                         ops[i], xs[i], ys[i], res, z, n, lat, leak, exp, exp == 0, model_neg(xs[i], ys[i]), W + 1);
            end
            $display("iterative op=%0d a=%h b=%h -> %h lat=%0d", ops[i], xs[i], ys[i], res, lat);
        end
    endtask

    task automatic test_shift_rotate();
        logic [31:0] res, exp, r4;
        logic z, n;
        int lat, leak;
        logic [3:0] op;
        logic [31:0] x, y;
        run_op(4'd7, 32'h8000_0001, 32'd4, r4, z, n, lat, leak);
        for (int i = 0; i < 24; i++) begin
            if (i == 0)      begin op = 4'd6; x = 32'h8000_0001; y = 32'd4;  end
            else if (i == 1) begin op = 4'd7; x = 32'h8000_0001; y = 32'd36; end
            else if (i == 2) begin op = 4'd4; x = 32'hDEAD_BEEF; y = 32'd32; end
            else if (i == 3) begin op = 4'd5; x = 32'hDEAD_BEEF; y = 32'd31; end
            else begin
                op = 4'($urandom_range(4, 7)); x = $urandom;
                y = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            end
            run_op(op, x, y, res, z, n, lat, leak);
            exp = model(op, x, y);
            n_vec++;
            if (res !== exp || z !== (exp == 0) || lat != 1) begin
                n_err++;
                $display("FAIL shift_rot op=%0d a=%h b=%0d: res=%h z=%b lat=%0d required %h %b 1",
                         op, x, y, res, z, lat, exp, exp == 0);
            end
            if (i == 1) begin
                n_vec++;
                if (res !== r4) begin
                    n_err++;
                    $display("FAIL rotr_wrap: b=36 gave %h required b=4 value %h", res, r4);
                end
            end
            $display("shift_rot op=%0d a=%h b=%0d -> %h", op, x, y, res);
        end
    endtask

    task automatic test_backpressure();
        logic bad;
        bus.in_valid = 1'b1; bus.a = 32'hA5A5_0000; bus.b = 32'h0000_A5A5; bus.alu_sel = 4'd10;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL bp_first: vld=%b res=%h required 1 a5a5a5a5", bus.out_valid, bus.result);
        end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                bus.in_valid = 1'b1; bus.a = 32'd1; bus.b = 32'd2; bus.alu_sel = 4'd0;
            end
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'hA5A5_A5A5) bad = 1'b1;
        end
        n_vec++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stall: result/handshake moved during stall, last res=%h rdy=%b required a5a5a5a5 0",
                     bus.result, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd3) begin
            n_err++;
            $display("FAIL bp_next_req: vld=%b res=%h required 1 00000003", bus.out_valid, bus.result);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("backpressure: 10-cycle stall then queued add accepted");
    endtask

    task automatic test_random();
        logic [31:0] res, exp, x, y;
        logic [3:0] op;
        logic z, n;
        int lat, leak, elat;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) y = x;
            run_op(op, x, y, res, z, n, lat, leak);
            exp = model(op, x, y);
            elat = (op == 4'd2 || op == 4'd3) ? W + 1 : 1;
            n_vec++;
            if (res !== exp || z !== (exp == 0) || n !== model_neg(x, y) || lat != elat || leak != 0) begin
                n_err++;
                $display("FAIL random op=%0d a=%h b=%h: res=%h z=%b n=%b lat=%0d leak=%0d required %h %b %b %0d 0",
                         op, x, y, res, z, n, lat, leak, exp, exp == 0, model_neg(x, y), elat);
            end
            $display("random op=%0d a=%h b=%h -> %h lat=%0d", op, x, y, res, lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.alu_sel = '0;
        @(negedge clk);
        test_reset();
        test_single_cycle();
        test_iterative();
        test_shift_rotate();
        test_backpressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
